dcache_controller: RTL



---
 rtl/dcache_pkg.sv | 37 +++
 rtl/dcache_line_array.sv | 53 +++++
 rtl/dcache_controller.sv | 107 ++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state type and address field helpers for the MEM-stage
// direct-mapped write-back data cache.
package dcache_pkg;

    localparam int ADDR_W   = 32;
    localparam int INDEX_W  = 5;
    localparam int OFFSET_W = 5;
    localparam int LINE_W   = 256;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORD_W   = 32;
    localparam int WSEL_W   = OFFSET_W - 2;
    localparam int LINES    = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] addrTag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addrIndex(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [WSEL_W-1:0] addrWord(input logic [ADDR_W-1:0] addr);
        return addr[2 +: WSEL_W];
    endfunction

    function automatic logic [ADDR_W-1:0] lineAddr(input logic [TAG_W-1:0] tag,
                                                    input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Per-line valid/dirty/tag/data storage with combinational read, full-line
// refill and single-word store ports.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [INDEX_W-1:0]  i_index,
    output logic                o_valid,
    output logic                o_dirty,
    output logic [TAG_W-1:0]    o_tag,
    output logic [LINE_W-1:0]   o_data,
    input  logic                i_refillEn,
    input  logic [TAG_W-1:0]    i_refillTag,
    input  logic [LINE_W-1:0]   i_refillData,
    input  logic                i_storeEn,
    input  logic [WSEL_W-1:0]   i_storeWord,
    input  logic [WORD_W-1:0]   i_storeData
);

    logic [LINES-1:0]  r_valid;
    logic [LINES-1:0]  r_dirty;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINE_W-1:0] r_data [LINES];

    assign o_valid = r_valid[i_index];
    assign o_dirty = r_dirty[i_index];
    assign o_tag   = r_tag[i_index];
    assign o_data  = r_data[i_index];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_refillEn) begin
            r_valid[i_index] <= 1'b1;
            r_dirty[i_index] <= 1'b0;
        end else if (i_storeEn) begin
            r_dirty[i_index] <= 1'b1;
        end
    end

    // Tags and data are left uncleared on reset; a cleared valid bit hides them.
    always_ff @(posedge i_clk) begin
        if (i_refillEn) begin
            r_tag[i_index]  <= i_refillTag;
            r_data[i_index] <= i_refillData;
        end else if (i_storeEn) begin
            r_data[i_index][{i_storeWord, 5'd0} +: WORD_W] <= i_storeData;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller: hit
// detection, pipeline stall, and the writeback/refill memory sequencer.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cpu_req_i,
    input  logic                cpu_write_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic [WORD_W-1:0]   cpu_data_i,
    output logic [WORD_W-1:0]   cpu_data_o,
    output logic                cpu_stall_o,
    output logic                mem_req_o,
    output logic                mem_write_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [LINE_W-1:0]   mem_data_o,
    input  logic [LINE_W-1:0]   mem_data_i,
    input  logic                mem_ack_i
);

    state_t             r_state;
    state_t             w_nextState;
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_index;
    logic [WSEL_W-1:0]  w_word;
    logic               w_lineValid;
    logic               w_lineDirty;
    logic [TAG_W-1:0]   w_lineTag;
    logic [LINE_W-1:0]  w_lineData;
    logic               w_hit;
    logic               w_storeEn;
    logic               w_refillEn;
    logic               w_unusedByteBits;

    assign w_tag            = addrTag(cpu_addr_i);
    assign w_index          = addrIndex(cpu_addr_i);
    assign w_word           = addrWord(cpu_addr_i);
    assign w_unusedByteBits = ^cpu_addr_i[1:0];

    dcache_line_array u_lines (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_index      (w_index),
        .o_valid      (w_lineValid),
        .o_dirty      (w_lineDirty),
        .o_tag        (w_lineTag),
        .o_data       (w_lineData),
        .i_refillEn   (w_refillEn),
        .i_refillTag  (w_tag),
        .i_refillData (mem_data_i),
        .i_storeEn    (w_storeEn),
        .i_storeWord  (w_word),
        .i_storeData  (cpu_data_i)
    );

    assign w_hit       = w_lineValid & (w_lineTag == w_tag);
    assign w_storeEn   = cpu_req_i & cpu_write_i & w_hit & (r_state == IDLE);
    assign w_refillEn  = (r_state == REFILL) & mem_ack_i;
    assign cpu_stall_o = cpu_req_i & (~w_hit | (r_state != IDLE));
    assign cpu_data_o  = (cpu_req_i & w_hit & ~cpu_write_i)
                       ? w_lineData[{w_word, 5'd0} +: WORD_W] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Memory outputs come straight from the state so reset drops mem_req_o at once.
    always_comb begin
        w_nextState = r_state;
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        case (r_state)
            IDLE: begin
                if (cpu_req_i & ~w_hit) begin
                    w_nextState = (w_lineValid & w_lineDirty) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = lineAddr(w_lineTag, w_index);
                mem_data_o  = w_lineData;
                if (mem_ack_i) begin
                    w_nextState = REFILL;
                end
            end
            REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = lineAddr(w_tag, w_index);
                if (mem_ack_i) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule
